// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding and word constants for the memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int W = 16;
  localparam logic [W-1:0] NOP = 16'h0000;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2} state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared memory port.
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; ();
  logic if_rd, if_done, if_stall;
  logic [W-1:0] if_addr, if_data;
  logic dm_rd, dm_wr, dm_done, dm_stall;
  logic [W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic mem_rd, mem_wr, mem_done, mem_stall, mem_err;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic err;
  modport master(
    output if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_done, mem_stall, mem_err,
    input if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall, mem_rd, mem_wr, mem_addr, mem_wdata, err
  );
  modport slave(
    input if_rd, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_done, mem_stall, mem_err,
    output if_data, if_done, if_stall, dm_rdata, dm_done, dm_stall, mem_rd, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// arb_timeout_cnt: saturating busy-cycle counter that flags expiry once it reaches LIMIT.
module arb_timeout_cnt #(
  parameter int CNT_W = 6,
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (en && cnt != LIM) ? cnt + 1'b1 : cnt;
  assign expire = en && cnt == LIM;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one stalling memory port between fetch and data access, data side first.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int MAX_DM_BURST = 4,
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  input logic halt,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DM_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DM_BURST);
  state_t state, next;
  logic [SW-1:0] streak, streak_n;
  logic [W-1:0] addr_q, wdata_q;
  logic wr_q, err_q, expire, dm_ok, if_ok, can_issue, gnt_if, gnt_dm, busy, fin;
  arb_timeout_cnt #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYC)) u_cnt (
    .clk(clk), .rst(rst), .clr(!busy), .en(busy), .expire(expire)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    dm_ok = bus.dm_rd ^ bus.dm_wr;
    if_ok = bus.if_rd & ~halt;
    can_issue = state == IDLE && !bus.mem_stall;
    gnt_if = can_issue && if_ok && (!dm_ok || streak == SMAX);
    gnt_dm = can_issue && dm_ok && !gnt_if;
    busy = state != IDLE;
    fin = busy && (bus.mem_done || expire);
    next = gnt_if ? BUSY_IF : gnt_dm ? BUSY_DM : fin ? IDLE : state;
    // Streak only grows while fetch is actually waiting behind the data side
    streak_n = gnt_if ? '0 : !gnt_dm ? streak : !bus.if_rd ? '0 : streak == SMAX ? SMAX : streak + 1'b1;
    bus.mem_rd = gnt_if || (gnt_dm && bus.dm_rd);
    bus.mem_wr = gnt_dm && bus.dm_wr;
    bus.mem_addr = gnt_if ? bus.if_addr : gnt_dm ? bus.dm_addr : addr_q;
    bus.mem_wdata = gnt_dm ? bus.dm_wdata : gnt_if ? NOP : wdata_q;
    bus.if_done = state == BUSY_IF && fin;
    bus.dm_done = state == BUSY_DM && fin;
    bus.if_data = (bus.if_done && bus.mem_done) ? bus.mem_rdata : NOP;
    bus.dm_rdata = (bus.dm_done && bus.mem_done && !wr_q) ? bus.mem_rdata : NOP;
    bus.if_stall = bus.if_rd && !bus.if_done;
    bus.dm_stall = (bus.dm_rd || bus.dm_wr) && !bus.dm_done;
    bus.err = err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
      addr_q <= NOP;
      wdata_q <= NOP;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      streak <= streak_n;
      if (gnt_if || gnt_dm) begin
        addr_q <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
        wr_q <= bus.mem_wr;
      end
      err_q <= err_q || (state == IDLE && bus.dm_rd && bus.dm_wr) || (fin && (!bus.mem_done || bus.mem_err));
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario checks for the shared memory port arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt = 1'b0;
  int checks = 0;
  int failures = 0;
  mem_port_arbiter_if bus();
  mem_port_arbiter dut(.clk(clk), .rst(rst), .halt(halt), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_in();
    bus.if_rd = 0; bus.if_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus.mem_rdata = 0; bus.mem_done = 0; bus.mem_stall = 0; bus.mem_err = 0; halt = 0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) begin failures++; $display("FAIL reset_issue got=%b exp=00", {bus.mem_rd, bus.mem_wr}); end
    checks++; if ({bus.if_done, bus.dm_done} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {bus.if_done, bus.dm_done}); end
    checks++; if (bus.mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", bus.mem_addr); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'h1111; #1;
    checks++; if ({bus.if_done, bus.dm_done, bus.if_data} !== 18'h0) begin failures++; $display("FAIL idle_done_ignored got=%h exp=0", {bus.if_done, bus.dm_done, bus.if_data}); end
    @(negedge clk); idle_in(); #1;
  endtask

  task automatic test_lone_if();
    @(negedge clk); bus.if_rd = 1; bus.if_addr = 16'h0010; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL if_issue got=%b/%h exp=1/0010", bus.mem_rd, bus.mem_addr); end
    checks++; if (bus.if_stall !== 1'b1) begin failures++; $display("FAIL if_stall_issue got=%b exp=1", bus.if_stall); end
    @(negedge clk); #1;
    checks++; if (bus.mem_rd !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL if_busy got=%b/%b/%h exp=0/0/0010", bus.mem_rd, bus.if_done, bus.mem_addr); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'hA5A5; #1;
    checks++; if (bus.if_done !== 1'b1 || bus.if_data !== 16'hA5A5) begin failures++; $display("FAIL if_done got=%b/%h exp=1/a5a5", bus.if_done, bus.if_data); end
    checks++; if (bus.if_stall !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL if_done_stall_err got=%b/%b exp=0/0", bus.if_stall, bus.err); end
    @(negedge clk); idle_in(); #1;
    checks++; if (bus.if_done !== 1'b0 || bus.if_data !== 16'h0000) begin failures++; $display("FAIL if_after got=%b/%h exp=0/0000", bus.if_done, bus.if_data); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); bus.if_rd = 1; bus.if_addr = 16'h0010; bus.dm_wr = 1; bus.dm_addr = 16'h0100; bus.dm_wdata = 16'h1234; #1;
    checks++; if ({bus.mem_wr, bus.mem_rd} !== 2'b10 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 16'h1234) begin failures++; $display("FAIL sim_dm_first got=%b%b/%h/%h exp=10/0100/1234", bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'hFFFF; #1;
    checks++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 16'h0000 || bus.if_done !== 1'b0) begin failures++; $display("FAIL sim_wr_done got=%b/%h/%b exp=1/0000/0", bus.dm_done, bus.dm_rdata, bus.if_done); end
    @(negedge clk); bus.dm_wr = 0; bus.mem_done = 0; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL sim_if_next got=%b/%h exp=1/0010", bus.mem_rd, bus.mem_addr); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'h5A5A; #1;
    checks++; if (bus.if_done !== 1'b1 || bus.if_data !== 16'h5A5A) begin failures++; $display("FAIL sim_if_done got=%b/%h exp=1/5a5a", bus.if_done, bus.if_data); end
    @(negedge clk); idle_in(); #1;
  endtask

  task automatic test_starvation();
    logic [6:0] exp_if = 7'b0010000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); bus.if_rd = 1; bus.if_addr = 16'h0020; bus.dm_rd = 1; bus.dm_addr = 16'h0200; bus.mem_done = 0; #1;
      checks++; if (bus.mem_rd !== 1'b1 || (bus.mem_addr == 16'h0020) !== exp_if[i]) begin failures++; $display("FAIL starve_grant%0d got=%b/%h exp_if=%b", i, bus.mem_rd, bus.mem_addr, exp_if[i]); end
      @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'h0100 + 16'(i); #1;
      checks++; if ({bus.if_done, bus.dm_done} !== {exp_if[i], ~exp_if[i]}) begin failures++; $display("FAIL starve_done%0d got=%b%b exp_if=%b", i, bus.if_done, bus.dm_done, exp_if[i]); end
    end
    @(negedge clk); idle_in(); #1;
  endtask

  task automatic test_mem_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.if_rd = 1; bus.if_addr = 16'h0030; bus.mem_stall = 1; #1;
      checks++; if (bus.mem_rd !== 1'b0 || bus.if_stall !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=%b/%b exp=0/1", i, bus.mem_rd, bus.if_stall); end
    end
    @(negedge clk); bus.mem_stall = 0; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0030 || bus.if_stall !== 1'b1) begin failures++; $display("FAIL stall_release got=%b/%h/%b exp=1/0030/1", bus.mem_rd, bus.mem_addr, bus.if_stall); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'h0303; #1;
    checks++; if (bus.if_done !== 1'b1 || bus.if_data !== 16'h0303) begin failures++; $display("FAIL stall_done got=%b/%h exp=1/0303", bus.if_done, bus.if_data); end
    @(negedge clk); idle_in(); #1;
  endtask

  task automatic test_timeout();
    int early = 0;
    @(negedge clk); bus.dm_rd = 1; bus.dm_addr = 16'h0300; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("FAIL to_issue got=%b/%b exp=1/0", bus.mem_rd, bus.err); end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); #1;
      if (bus.dm_done !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL to_early got=%0d exp=0", early); end
    @(negedge clk); #1;
    checks++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 16'h0000 || bus.dm_stall !== 1'b0) begin failures++; $display("FAIL to_expire got=%b/%h/%b exp=1/0000/0", bus.dm_done, bus.dm_rdata, bus.dm_stall); end
    @(negedge clk); bus.dm_rd = 0; bus.mem_done = 1; bus.mem_rdata = 16'hDEAD; #1;
    checks++; if ({bus.dm_done, bus.if_done, bus.dm_rdata} !== 18'h0) begin failures++; $display("FAIL to_late_ignored got=%h exp=0", {bus.dm_done, bus.if_done, bus.dm_rdata}); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", bus.err); end
    @(negedge clk); bus.mem_done = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", bus.err); end
  endtask

  task automatic test_illegal();
    @(negedge clk); idle_in(); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL ill_rst_clears got=%b exp=0", bus.err); end
    @(negedge clk); bus.dm_rd = 1; bus.dm_wr = 1; bus.dm_addr = 16'h0500; #1;
    checks++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00 || bus.dm_stall !== 1'b1) begin failures++; $display("FAIL ill_no_issue got=%b%b/%b exp=00/1", bus.mem_rd, bus.mem_wr, bus.dm_stall); end
    @(negedge clk); bus.if_rd = 1; bus.if_addr = 16'h0050; #1;
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", bus.err); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_addr !== 16'h0050) begin failures++; $display("FAIL ill_if_grant got=%b%b/%h exp=10/0050", bus.mem_rd, bus.mem_wr, bus.mem_addr); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'h0505; #1;
    checks++; if (bus.if_done !== 1'b1 || bus.dm_done !== 1'b0) begin failures++; $display("FAIL ill_done got=%b%b exp=10", bus.if_done, bus.dm_done); end
    @(negedge clk); idle_in(); #1;
  endtask

  task automatic test_halt_reset();
    @(negedge clk); halt = 1; bus.if_rd = 1; bus.if_addr = 16'h0040; bus.dm_rd = 1; bus.dm_addr = 16'h0400; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0400) begin failures++; $display("FAIL halt_dm_served got=%b/%h exp=1/0400", bus.mem_rd, bus.mem_addr); end
    @(negedge clk); bus.mem_done = 1; bus.mem_rdata = 16'h4444; #1;
    checks++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 16'h4444) begin failures++; $display("FAIL halt_dm_done got=%b/%h exp=1/4444", bus.dm_done, bus.dm_rdata); end
    @(negedge clk); bus.dm_rd = 0; bus.mem_done = 0; #1;
    checks++; if (bus.mem_rd !== 1'b0 || bus.if_stall !== 1'b1) begin failures++; $display("FAIL halt_blocks_if got=%b/%b exp=0/1", bus.mem_rd, bus.if_stall); end
    @(negedge clk); halt = 0; #1;
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0040) begin failures++; $display("FAIL unhalt_if got=%b/%h exp=1/0040", bus.mem_rd, bus.mem_addr); end
    @(negedge clk); rst = 1; #1;
    @(negedge clk); rst = 0; bus.if_rd = 0; bus.mem_done = 1; bus.mem_rdata = 16'hBEEF; #1;
    checks++; if (bus.if_done !== 1'b0 || bus.if_data !== 16'h0000) begin failures++; $display("FAIL rst_drop got=%b/%h exp=0/0000", bus.if_done, bus.if_data); end
    checks++; if (bus.err !== 1'b0 || {bus.mem_rd, bus.mem_wr} !== 2'b00 || bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 16'h0000) begin failures++; $display("FAIL rst_outputs got=%b/%b%b/%h/%h exp=0/00/0000/0000", bus.err, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
    @(negedge clk); idle_in(); #1;
  endtask

  initial begin
    test_reset();
    test_lone_if();
    test_simultaneous();
    test_starvation();
    test_mem_stall();
    test_timeout();
    test_illegal();
    test_halt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory port (stalling memory: mem_stall/mem_done handshake) between instruction fetch (read-only) and data memory access (read/write).
- Sits between the fetch stage and the memory stage on one side and the single memory instance on the other.
- Data-side priority with a starvation guard for fetch, a halt gate on fetch, a response timeout, and a sticky error flag.

Parameters:
- MAX_DM_BURST, 4: max consecutive DM grants while an IF read is pending; the next grant then goes to IF.
- TIMEOUT_CYC, 32: cycles in a BUSY state with no mem_done before the transaction is aborted.
- CNT_W, 6: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- halt  in  1  blocks new IF grants
- if_rd  in  1  fetch read request, held until if_done
- if_addr  in  16  fetch address
- if_data  out  16  fetch read data, valid with if_done
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  if_rd & ~if_done
- dm_rd  in  1  data read request, held until dm_done
- dm_wr  in  1  data write request, held until dm_done
- dm_addr  in  16  data address
- dm_wdata  in  16  write data
- dm_rdata  out  16  data read result, valid with dm_done
- dm_done  out  1  one-cycle completion pulse to data side
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- mem_rd  out  1  one-cycle read issue to memory
- mem_wr  out  1  one-cycle write issue to memory
- mem_addr  out  16  address to memory
- mem_wdata  out  16  write data to memory
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse
- mem_stall  in  1  memory cannot accept a new request
- mem_err  in  1  memory error, sampled with mem_done
- err  out  1  sticky error, cleared only by rst

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, dm_streak=0, timeout counter=0, err=0.
  - All done, mem_rd and mem_wr outputs are 0; data outputs are 16'h0000.
  - A mem_done arriving while in IDLE is ignored. An in-flight response across reset is dropped.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE grant decision (combinational; issue happens in the same cycle; nothing is issued while mem_stall=1):
  - dm_ok = (dm_rd ^ dm_wr).
  - if_ok = if_rd & ~halt.
  - Grant IF if if_ok & (~dm_ok | dm_streak==MAX_DM_BURST). Otherwise grant DM if dm_ok.
  - On a grant: pulse mem_rd or mem_wr for exactly 1 cycle. Drive mem_addr and mem_wdata from the winner. Go to BUSY_IF or BUSY_DM.
- dm_streak:
  - Increments on a DM grant while if_rd=1.
  - Clears on an IF grant, or on a DM grant while if_rd=0.
  - Saturates at MAX_DM_BURST.
- dm_rd & dm_wr both high in IDLE (illegal):
  - Set err. Do not issue the DM request; it stays pending.
  - IF may still be granted.
- BUSY_x:
  - mem_addr and mem_wdata hold the issued values. mem_rd and mem_wr are 0.
  - Timeout counter increments each cycle.
  - On mem_done: pass mem_rdata to if_data or dm_rdata combinationally, pulse x_done, set err if mem_err, clear the counter, return to IDLE.
  - Writes also complete on mem_done; dm_rdata is 16'h0000 for writes.
- Timeout:
  - If the counter reaches TIMEOUT_CYC with no mem_done: pulse x_done with data 16'h0000, set err, go to IDLE.
  - A late mem_done arriving in IDLE is ignored.
- Throughput:
  - Minimum 2 cycles per transaction: the issue cycle, then the done cycle (memory done at the earliest one cycle after issue). The next issue is possible the cycle after done.
  - Arbiter latency on the response path is 0 cycles.
- halt:
  - Affects only new IF grants. An in-flight IF transaction completes normally.
  - DM continues to be served.
  - The if_stall formula is unchanged while halted (fetch sees stall).
- Non-done outputs (if_data, dm_rdata) are 16'h0000 whenever the matching done is 0.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2);
  - the 16-bit word/address width constant;
  - NOP data 16'h0000.
- One sub-module is natural: arb_timeout_cnt (a CNT_W counter with clear, enable and expire output), reusable for other stalling-memory clients.

Test Plan:
- Lone IF read: if_rd=1, if_addr=16'h0010, memory done 2 cycles later with 16'hA5A5 -> mem_rd pulses in cycle 0 with mem_addr=16'h0010; if_done=1 and if_data=16'hA5A5 in the done cycle; err=0.
- Simultaneous requests: if_rd and dm_wr (dm_addr=16'h0100, dm_wdata=16'h1234), streak=0 -> DM is granted first (mem_wr=1, mem_wdata=16'h1234); after dm_done, the next issue is IF at 16'h0010.
- Starvation: IF pending while DM issues 6 back-to-back reads, MAX_DM_BURST=4 -> grant order DM,DM,DM,DM,IF,DM,DM.
- mem_stall: mem_stall=1 for 3 cycles with if_rd=1 -> no mem_rd during those cycles; mem_rd is issued the first cycle mem_stall=0; if_stall=1 throughout.
- Timeout: grant DM read, memory never responds -> after 32 BUSY cycles dm_done=1, dm_rdata=16'h0000, err=1. A subsequent late mem_done is ignored. err stays 1 until rst.
- Halt and reset: halt=1 with if_rd=1 -> no IF issue while DM is still served. Assert rst during BUSY_IF -> the next cycle is IDLE with err=0 and all outputs 0; the dropped mem_done does not cause if_done.
